// File: rtl/ghost_board_writer.sv
// Ghost board writer: on a ghost move, restores tiles under the old ghost cells, saves the
// tiles under the new cells, draws both ghosts there and reports landings on pacman.
module ghost_board_writer #(
    parameter int unsigned       TILE_W     = 3,
    parameter logic [TILE_W-1:0] EMPTY_CODE = TILE_W'(0),
    parameter logic [TILE_W-1:0] GHOST_CODE = TILE_W'(4)
) (
    input  logic              i_clock_50,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [5:0]        i_curr_ghost1_x,
    input  logic [4:0]        i_curr_ghost1_y,
    input  logic [5:0]        i_curr_ghost2_x,
    input  logic [4:0]        i_curr_ghost2_y,
    input  logic [5:0]        i_next_ghost1_x,
    input  logic [4:0]        i_next_ghost1_y,
    input  logic [5:0]        i_next_ghost2_x,
    input  logic [4:0]        i_next_ghost2_y,
    input  logic [5:0]        i_curr_pacman_x,
    input  logic [4:0]        i_curr_pacman_y,
    output logic [5:0]        o_rd_x,
    output logic [4:0]        o_rd_y,
    input  logic [TILE_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [5:0]        o_wr_x,
    output logic [4:0]        o_wr_y,
    output logic [TILE_W-1:0] o_wr_data,
    output logic              o_wrdone,
    output logic              o_busy,
    output logic              o_collision,
    output logic [1:0]        o_collision_id,
    output logic              o_stale_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERASE1, S_ERASE2, S_RD1, S_WAIT1,
        S_DRAW1, S_RD2, S_WAIT2, S_DRAW2, S_DONE
    } state_t;

    state_t              r_state;
    logic                r_hold;
    logic [5:0]          r_t1_x, r_t2_x, r_o2_x;
    logic [4:0]          r_t1_y, r_t2_y, r_o2_y;
    logic [TILE_W-1:0]   r_under1, r_under2;
    logic [5:0]          r_rd_x, r_wr_x;
    logic [4:0]          r_rd_y, r_wr_y;
    logic [TILE_W-1:0]   r_wr_data;
    logic                r_wr_en, r_wrdone, r_busy, r_collision, r_stale_err;
    logic [1:0]          r_collision_id;

    logic w_moved, w_start, w_t1_on_pac, w_t2_on_pac, w_same_target, w_stale;

    assign w_moved       = (i_next_ghost1_x != i_curr_ghost1_x) || (i_next_ghost1_y != i_curr_ghost1_y) ||
                           (i_next_ghost2_x != i_curr_ghost2_x) || (i_next_ghost2_y != i_curr_ghost2_y);
    assign w_start       = (r_state == S_IDLE) && i_enable && !r_hold && w_moved;
    assign w_t1_on_pac   = (r_t1_x == i_curr_pacman_x) && (r_t1_y == i_curr_pacman_y);
    assign w_t2_on_pac   = (r_t2_x == i_curr_pacman_x) && (r_t2_y == i_curr_pacman_y);
    assign w_same_target = (r_t1_x == r_t2_x) && (r_t1_y == r_t2_y);
    assign w_stale       = (i_next_ghost1_x != r_t1_x) || (i_next_ghost1_y != r_t1_y) ||
                           (i_next_ghost2_x != r_t2_x) || (i_next_ghost2_y != r_t2_y);

    // Outputs are registered for the state being entered, so each lines up with its state.
    always_ff @(posedge i_clock_50 or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_hold         <= 1'b0;
            r_t1_x         <= '0;
            r_t1_y         <= '0;
            r_t2_x         <= '0;
            r_t2_y         <= '0;
            r_o2_x         <= '0;
            r_o2_y         <= '0;
            r_under1       <= EMPTY_CODE;
            r_under2       <= EMPTY_CODE;
            r_rd_x         <= '0;
            r_rd_y         <= '0;
            r_wr_en        <= 1'b0;
            r_wr_x         <= '0;
            r_wr_y         <= '0;
            r_wr_data      <= '0;
            r_wrdone       <= 1'b0;
            r_busy         <= 1'b0;
            r_collision    <= 1'b0;
            r_collision_id <= 2'b00;
            r_stale_err    <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_data   <= '0;
            r_rd_x      <= '0;
            r_rd_y      <= '0;
            r_wrdone    <= 1'b0;
            r_collision <= 1'b0;
            r_hold      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_t1_x         <= i_next_ghost1_x;
                        r_t1_y         <= i_next_ghost1_y;
                        r_t2_x         <= i_next_ghost2_x;
                        r_t2_y         <= i_next_ghost2_y;
                        r_o2_x         <= i_curr_ghost2_x;
                        r_o2_y         <= i_curr_ghost2_y;
                        r_collision_id <= 2'b00;
                        r_busy         <= 1'b1;
                        r_wr_en        <= 1'b1;
                        r_wr_x         <= i_curr_ghost1_x;
                        r_wr_y         <= i_curr_ghost1_y;
                        r_wr_data      <= r_under1;
                        r_state        <= S_ERASE1;
                    end
                end
                S_ERASE1: begin
                    r_wr_en   <= 1'b1;
                    r_wr_x    <= r_o2_x;
                    r_wr_y    <= r_o2_y;
                    r_wr_data <= r_under2;
                    r_state   <= S_ERASE2;
                end
                S_ERASE2: begin
                    r_rd_x  <= r_t1_x;
                    r_rd_y  <= r_t1_y;
                    r_state <= S_RD1;
                end
                S_RD1: begin
                    r_rd_x  <= r_t1_x;
                    r_rd_y  <= r_t1_y;
                    r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    r_wr_en   <= 1'b1;
                    r_wr_x    <= r_t1_x;
                    r_wr_y    <= r_t1_y;
                    r_wr_data <= GHOST_CODE;
                    r_state   <= S_DRAW1;
                end
                S_DRAW1: begin
                    r_under1 <= i_rd_data;
                    if (w_t1_on_pac) r_collision_id[0] <= 1'b1;
                    r_rd_x   <= r_t2_x;
                    r_rd_y   <= r_t2_y;
                    r_state  <= S_RD2;
                end
                S_RD2: begin
                    r_rd_x  <= r_t2_x;
                    r_rd_y  <= r_t2_y;
                    r_state <= S_WAIT2;
                end
                S_WAIT2: begin
                    r_wr_en   <= 1'b1;
                    r_wr_x    <= r_t2_x;
                    r_wr_y    <= r_t2_y;
                    r_wr_data <= GHOST_CODE;
                    r_state   <= S_DRAW2;
                end
                S_DRAW2: begin
                    // A shared target now reads back GHOST_CODE; ghost1 already saved the real tile.
                    r_under2    <= w_same_target ? r_under1 : i_rd_data;
                    if (w_t2_on_pac) r_collision_id[1] <= 1'b1;
                    r_collision <= r_collision_id[0] | w_t2_on_pac;
                    r_wrdone    <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (w_stale) r_stale_err <= 1'b1;
                    r_busy  <= 1'b0;
                    r_hold  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_x         = r_rd_x;
    assign o_rd_y         = r_rd_y;
    assign o_wr_en        = r_wr_en;
    assign o_wr_x         = r_wr_x;
    assign o_wr_y         = r_wr_y;
    assign o_wr_data      = r_wr_data;
    assign o_wrdone       = r_wrdone;
    assign o_busy         = r_busy;
    assign o_collision    = r_collision;
    assign o_collision_id = r_collision_id;
    assign o_stale_err    = r_stale_err;

endmodule
